// File: rtl/outerprodrc_ctrl_pkg.sv
// Shared definitions for the unary outer-product GEMM sequencer.
// Holds the controller state encoding, the unary stream period helper and
// the default width of tile counts / indices.
package outerprodrc_ctrl_pkg;

  localparam int DIMW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_OUT   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // A unary stream of b-bit precision needs 2^b cycles to represent a value.
  function automatic int runlen(input int bitwidth);
    return 32'sd1 << bitwidth;
  endfunction

endpackage

// File: rtl/outerprodrc_ctrl_idx.sv
// Nested tile/chunk index counter for the GEMM sequencer.
// k is the innermost (reduction chunk) index; tiles advance n fastest, then m.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             force m=n=k=0 (new job)
//   inc_k             advance k, wrapping to 0 after the last chunk
//   inc_tile          advance to the next output tile (n fastest)
//   num_m/num_n/num_k latched job dimensions
//   m, n, k           current indices
//   last_k, last_tile current chunk / tile is the final one
module outerprodrc_ctrl_idx
  import outerprodrc_ctrl_pkg::*;
#(
  parameter int DIMW = DIMW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            inc_k,
  input  logic            inc_tile,
  input  logic [DIMW-1:0] num_m,
  input  logic [DIMW-1:0] num_n,
  input  logic [DIMW-1:0] num_k,
  output logic [DIMW-1:0] m,
  output logic [DIMW-1:0] n,
  output logic [DIMW-1:0] k,
  output logic            last_k,
  output logic            last_tile
);

  localparam logic [DIMW-1:0] IDX_ONE  = {{(DIMW-1){1'b0}}, 1'b1};
  localparam logic [DIMW-1:0] IDX_ZERO = {DIMW{1'b0}};

  logic [DIMW-1:0] m_r;
  logic [DIMW-1:0] n_r;
  logic [DIMW-1:0] k_r;
  logic            last_m_s;
  logic            last_n_s;

  assign last_m_s  = (m_r == (num_m - IDX_ONE));
  assign last_n_s  = (n_r == (num_n - IDX_ONE));
  assign last_k    = (k_r == (num_k - IDX_ONE));
  assign last_tile = last_m_s && last_n_s;

  assign m = m_r;
  assign n = n_r;
  assign k = k_r;

  // Index registers: clear wins over any increment.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      m_r <= IDX_ZERO;
      n_r <= IDX_ZERO;
      k_r <= IDX_ZERO;
    end else begin
      if (inc_k) begin
        k_r <= last_k ? IDX_ZERO : (k_r + IDX_ONE);
      end
      if (inc_tile) begin
        if (last_n_s) begin
          n_r <= IDX_ZERO;
          m_r <= last_m_s ? IDX_ZERO : (m_r + IDX_ONE);
        end else begin
          n_r <= n_r + IDX_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/outerprodrc_ctrl.sv
// Sequencer for the unary outer-product GEMM array.
// Walks the M x N output tiles, and for each tile the K reduction chunks:
// fetch operands, stream them through the array for 2^BITWIDTH cycles,
// let the array pipeline drain, then hand the tile out via valid/ready.
// Ports:
//   iClk, iRst                     clock, synchronous active-high reset
//   iStart, iNumM/N/K              job start and dimensions (latched on start)
//   oBusy, oDone                   job in progress / one-cycle completion pulse
//   oFetchReq, oFetchM/N/K         operand chunk request and its indices
//   iFetchAck                      operand chunk delivered
//   oArrClr, oArrLoad, oArrEn      array accumulator clear, operand load, enable
//   oOutValid, iOutReady, oOutM/N  finished-tile handshake and tile indices
// All outputs are registered (decoded from the next state) except oArrLoad,
// which must coincide with the cycle the fetch is acknowledged.
module outerprodrc_ctrl
  import outerprodrc_ctrl_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int DIMW      = DIMW_DEF,
  parameter int DRAIN_CYC = 2
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iStart,
  input  logic [DIMW-1:0] iNumM,
  input  logic [DIMW-1:0] iNumN,
  input  logic [DIMW-1:0] iNumK,
  output logic            oBusy,
  output logic            oDone,
  output logic            oFetchReq,
  output logic [DIMW-1:0] oFetchM,
  output logic [DIMW-1:0] oFetchN,
  output logic [DIMW-1:0] oFetchK,
  input  logic            iFetchAck,
  output logic            oArrClr,
  output logic            oArrLoad,
  output logic            oArrEn,
  output logic            oOutValid,
  input  logic            iOutReady,
  output logic [DIMW-1:0] oOutM,
  output logic [DIMW-1:0] oOutN
);

  localparam int                  RUNLEN     = runlen(BITWIDTH);
  localparam logic [BITWIDTH-1:0] STREAM_END = BITWIDTH'(RUNLEN - 1);
  localparam logic [BITWIDTH-1:0] STREAM_ONE = {{(BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]          DRAIN_END  = 4'(DRAIN_CYC - 1);
  localparam logic [DIMW-1:0]     IDX_ZERO   = {DIMW{1'b0}};

  state_e          state_r;
  state_e          state_nxt_s;
  logic [DIMW-1:0] num_m_r;
  logic [DIMW-1:0] num_n_r;
  logic [DIMW-1:0] num_k_r;
  logic [BITWIDTH-1:0] stream_cnt_r;
  logic [3:0]      drain_cnt_r;
  logic            latch_s;
  logic            clear_idx_s;
  logic            inc_k_s;
  logic            inc_tile_s;
  logic            last_k_s;
  logic            last_tile_s;
  logic [DIMW-1:0] m_s;
  logic [DIMW-1:0] n_s;
  logic [DIMW-1:0] k_s;
  logic            busy_r;
  logic            done_r;
  logic            fetch_req_r;
  logic            clr_r;
  logic            en_r;
  logic            out_valid_r;

  outerprodrc_ctrl_idx #(
    .DIMW (DIMW)
  ) u_idx (
    .clk       (iClk),
    .rst       (iRst),
    .clear     (clear_idx_s),
    .inc_k     (inc_k_s),
    .inc_tile  (inc_tile_s),
    .num_m     (num_m_r),
    .num_n     (num_n_r),
    .num_k     (num_k_r),
    .m         (m_s),
    .n         (n_s),
    .k         (k_s),
    .last_k    (last_k_s),
    .last_tile (last_tile_s)
  );

  // Next-state and index-control decode.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    clear_idx_s = 1'b0;
    inc_k_s     = 1'b0;
    inc_tile_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (iStart) begin
          latch_s     = 1'b1;
          clear_idx_s = 1'b1;
          // An empty job completes immediately without touching the array.
          if ((iNumM == IDX_ZERO) || (iNumN == IDX_ZERO) || (iNumK == IDX_ZERO)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CLR;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (iFetchAck) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_RUN: begin
        if (stream_cnt_r == STREAM_END) begin
          inc_k_s = 1'b1;
          if (last_k_s) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_END) begin
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (iOutReady) begin
          inc_tile_s = 1'b1;
          if (last_tile_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CLR;
          end
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and job-dimension latch.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r <= ST_IDLE;
      num_m_r <= IDX_ZERO;
      num_n_r <= IDX_ZERO;
      num_k_r <= IDX_ZERO;
    end else begin
      state_r <= state_nxt_s;
      if (latch_s) begin
        num_m_r <= iNumM;
        num_n_r <= iNumN;
        num_k_r <= iNumK;
      end
    end
  end

  // Stream-period and drain counters; both idle at zero outside their state.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stream_cnt_r <= {BITWIDTH{1'b0}};
      drain_cnt_r  <= 4'd0;
    end else begin
      stream_cnt_r <= (state_r == ST_RUN)   ? (stream_cnt_r + STREAM_ONE) : {BITWIDTH{1'b0}};
      drain_cnt_r  <= (state_r == ST_DRAIN) ? (drain_cnt_r + 4'd1)        : 4'd0;
    end
  end

  // Registered control outputs, decoded from the state being entered so they
  // line up with that state's cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fetch_req_r <= 1'b0;
      clr_r       <= 1'b0;
      en_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_nxt_s == ST_DONE);
      fetch_req_r <= (state_nxt_s == ST_FETCH);
      clr_r       <= (state_nxt_s == ST_CLR);
      en_r        <= (state_nxt_s == ST_RUN);
      out_valid_r <= (state_nxt_s == ST_OUT);
    end
  end

  assign oBusy     = busy_r;
  assign oDone     = done_r;
  assign oFetchReq = fetch_req_r;
  assign oArrClr   = clr_r;
  assign oArrEn    = en_r;
  assign oOutValid = out_valid_r;
  assign oArrLoad  = (state_r == ST_FETCH) && iFetchAck;
  // Index registers only move on state transitions, so they are already
  // stable for the whole FETCH / OUT window.
  assign oFetchM   = m_s;
  assign oFetchN   = n_s;
  assign oFetchK   = k_s;
  assign oOutM     = m_s;
  assign oOutN     = n_s;

endmodule

// File: tb/tb_outerprodrc_ctrl.sv
// Self-checking bench for outerprodrc_ctrl (BITWIDTH=3 -> 8-cycle stream,
// DRAIN_CYC=2). Job vectors come from a table; fetch and output indices are
// checked against scoreboard queues filled when each job is started.
module tb_outerprodrc_ctrl;

  localparam int BW = 3;
  localparam int DW = 8;
  localparam int DC = 2;
  localparam int RL = 8;

  logic          iClk;
  logic          iRst;
  logic          iStart;
  logic [DW-1:0] iNumM;
  logic [DW-1:0] iNumN;
  logic [DW-1:0] iNumK;
  logic          oBusy;
  logic          oDone;
  logic          oFetchReq;
  logic [DW-1:0] oFetchM;
  logic [DW-1:0] oFetchN;
  logic [DW-1:0] oFetchK;
  logic          iFetchAck;
  logic          oArrClr;
  logic          oArrLoad;
  logic          oArrEn;
  logic          oOutValid;
  logic          iOutReady;
  logic [DW-1:0] oOutM;
  logic [DW-1:0] oOutN;

  outerprodrc_ctrl #(
    .BITWIDTH  (BW),
    .DIMW      (DW),
    .DRAIN_CYC (DC)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iNumM     (iNumM),
    .iNumN     (iNumN),
    .iNumK     (iNumK),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oFetchReq (oFetchReq),
    .oFetchM   (oFetchM),
    .oFetchN   (oFetchN),
    .oFetchK   (oFetchK),
    .iFetchAck (iFetchAck),
    .oArrClr   (oArrClr),
    .oArrLoad  (oArrLoad),
    .oArrEn    (oArrEn),
    .oOutValid (oOutValid),
    .iOutReady (iOutReady),
    .oOutM     (oOutM),
    .oOutN     (oOutN)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    int m; int n; int k;
    int ack_d; int rdy_d; int glitch;
    int exp_busy; int exp_clr; int exp_load; int exp_en; int exp_tiles;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   fetch_q[$];
  int   out_q[$];
  int   cyc, ack_delay, rdy_delay, fetch_wait, rdy_wait;
  int   busy_cnt, done_cnt, clr_cnt, load_cnt, en_cnt, tile_cnt, en_run;
  int   first_clr, first_load, first_en, last_en, first_out, first_done, first_busy, last_busy;
  logic        hold_req, hold_out;
  logic [23:0] hold_fidx;
  logic [15:0] hold_oidx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshake responder: ack/ready tied high when the delay is 0, otherwise
  // asserted after 'delay' waiting cycles of req/valid.
  task automatic drive_hs();
    if (ack_delay == 0) iFetchAck = 1'b1;
    else if (oFetchReq) begin
      if (fetch_wait == ack_delay) begin iFetchAck = 1'b1; fetch_wait = 0; end
      else begin iFetchAck = 1'b0; fetch_wait++; end
    end else begin iFetchAck = 1'b0; fetch_wait = 0; end
    if (rdy_delay == 0) iOutReady = 1'b1;
    else if (oOutValid) begin
      if (rdy_wait == rdy_delay) begin iOutReady = 1'b1; rdy_wait = 0; end
      else begin iOutReady = 1'b0; rdy_wait++; end
    end else begin iOutReady = 1'b0; rdy_wait = 0; end
  endtask

  task automatic sample();
    int exp;
    if (iRst) begin
      en_run = 0; hold_req = 1'b0; hold_out = 1'b0;
    end else begin
      if (oBusy) begin busy_cnt++; if (first_busy < 0) first_busy = cyc; last_busy = cyc; end
      if (oDone) begin done_cnt++; if (first_done < 0) first_done = cyc; end
      if (oArrClr) begin clr_cnt++; if (first_clr < 0) first_clr = cyc; end
      if (oArrLoad) begin
        load_cnt++;
        if (first_load < 0) first_load = cyc;
        if (fetch_q.size() == 0) check("fetch_unexpected", 32'd1, 32'd0);
        else begin
          exp = fetch_q.pop_front();
          check("fetch_idx", 32'({oFetchM, oFetchN, oFetchK}), exp);
        end
      end
      if (hold_req) check("fetch_hold", 32'({oFetchReq, oFetchM, oFetchN, oFetchK}), 32'({1'b1, hold_fidx}));
      hold_req  = oFetchReq && !iFetchAck;
      hold_fidx = {oFetchM, oFetchN, oFetchK};
      if (oOutValid) begin
        if (first_out < 0) first_out = cyc;
        check("out_quiet", 32'({oArrEn, oArrClr, oFetchReq}), 32'd0);
        if (iOutReady) begin
          tile_cnt++;
          if (out_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
          else begin
            exp = out_q.pop_front();
            check("out_idx", 32'({oOutM, oOutN}), exp);
          end
        end
      end
      if (hold_out) check("out_hold", 32'({oOutValid, oOutM, oOutN}), 32'({1'b1, hold_oidx}));
      hold_out  = oOutValid && !iOutReady;
      hold_oidx = {oOutM, oOutN};
      if (oArrEn) begin
        en_cnt++; en_run++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else begin
        if (en_run != 0) check("en_run_len", en_run, RL);
        en_run = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge iClk);
    cyc++;
    drive_hs();
    #1;
    sample();
  endtask

  task automatic start_job(input int m, input int n, input int k);
    if (m > 0 && n > 0 && k > 0) begin
      for (int mm = 0; mm < m; mm++)
        for (int nn = 0; nn < n; nn++) begin
          out_q.push_back((mm << 8) | nn);
          for (int kk = 0; kk < k; kk++) fetch_q.push_back((mm << 16) | (nn << 8) | kk);
        end
    end
    busy_cnt = 0; done_cnt = 0; clr_cnt = 0; load_cnt = 0; en_cnt = 0; tile_cnt = 0;
    first_clr = -1; first_load = -1; first_en = -1; last_en = -1;
    first_out = -1; first_done = -1; first_busy = -1; last_busy = -1;
    iNumM = DW'(m); iNumN = DW'(n); iNumK = DW'(k);
    iStart = 1'b1;
    cyc = 0;
    tick();
    iStart = 1'b0;
    // Junk dimensions for the rest of the job: a relatch would show up.
    iNumM = 8'd7; iNumN = 8'd7; iNumK = 8'd7;
  endtask

  task automatic run_vec(input vec_t v);
    ack_delay = v.ack_d; rdy_delay = v.rdy_d;
    start_job(v.m, v.n, v.k);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      iStart = (v.glitch != 0 && cyc == 20) ? 1'b1 : 1'b0;
      tick();
    end
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    // Optionally raise start during the DONE cycle; it must be ignored.
    iStart = (v.glitch != 0) ? 1'b1 : 1'b0;
    tick();
    iStart = 1'b0;
    check("idle_after_done", 32'({oBusy, oDone, oArrClr, oFetchReq}), 32'd0);
    check("done_count", done_cnt, 32'd1);
    check("busy_cycles", busy_cnt, v.exp_busy);
    check("clr_count", clr_cnt, v.exp_clr);
    check("load_count", load_cnt, v.exp_load);
    check("en_cycles", en_cnt, v.exp_en);
    check("tile_count", tile_cnt, v.exp_tiles);
    check("queues_drained", 32'(fetch_q.size() + out_q.size()), 32'd0);
  endtask

  initial begin
    //            m  n  k  ackd rdyd gl busy clr load en tiles
    vecs[0] = '{1, 1, 1, 0, 0,  0, 14, 1, 1, 8,  1};
    vecs[1] = '{2, 3, 1, 0, 0,  0, 79, 6, 6, 48, 6};
    vecs[2] = '{1, 1, 3, 4, 0,  0, 44, 1, 3, 24, 1};
    vecs[3] = '{1, 2, 2, 0, 10, 0, 65, 2, 4, 32, 2};
    vecs[4] = '{2, 2, 0, 0, 0,  1, 1,  0, 0, 0,  0};
    vecs[5] = '{2, 1, 2, 1, 2,  1, 53, 2, 4, 32, 2};
    vecs[6] = '{0, 3, 3, 0, 0,  0, 1,  0, 0, 0,  0};

    iRst = 1'b1; iStart = 1'b0; iNumM = 8'd0; iNumN = 8'd0; iNumK = 8'd0;
    iFetchAck = 1'b0; iOutReady = 1'b0;
    ack_delay = 0; rdy_delay = 0; fetch_wait = 0; rdy_wait = 0; cyc = 0;
    en_run = 0; hold_req = 1'b0; hold_out = 1'b0; hold_fidx = 24'd0; hold_oidx = 16'd0;
    repeat (3) tick();
    check("reset_ctrl", 32'({oBusy, oDone, oFetchReq, oArrClr, oArrLoad, oArrEn, oOutValid}), 32'd0);
    check("reset_idx", 32'({oFetchM, oFetchN, oFetchK, oOutM}), 32'd0);
    iRst = 1'b0;
    tick();

    // Single-tile job: exact cycle placement of each phase.
    run_vec(vecs[0]);
    check("t_first_busy", first_busy, 32'd1);
    check("t_last_busy", last_busy, 32'd14);
    check("t_clr", first_clr, 32'd1);
    check("t_load", first_load, 32'd2);
    check("t_en_first", first_en, 32'd3);
    check("t_en_last", last_en, 32'd10);
    check("t_out", first_out, 32'd13);
    check("t_done", first_done, 32'd14);

    for (int i = 1; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of RUN abandons the job.
    ack_delay = 0; rdy_delay = 0;
    start_job(1, 1, 2);
    repeat (3) tick();
    check("pre_rst_en", 32'(oArrEn), 32'd1);
    iRst = 1'b1;
    tick();
    check("rst_ctrl", 32'({oBusy, oDone, oFetchReq, oArrClr, oArrLoad, oArrEn, oOutValid}), 32'd0);
    check("rst_idx", 32'({oFetchM, oFetchN, oFetchK, oOutM}), 32'd0);
    iRst = 1'b0;
    fetch_q.delete(); out_q.delete();
    tick();
    check("rst_no_done", done_cnt, 32'd0);
    run_vec('{1, 2, 1, 0, 0, 0, 27, 2, 2, 16, 2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/outerprodrc_ctrl.md
Name: outerprodrc_ctrl

Overview:
Sequencer for the unary outer-product GEMM array. Walks an M x N output-tile grid and a K-chunk reduction loop, and requests operand chunks from the buffer side. Drives the array's enable, clear and load controls, with each chunk running a full unary stream period of 2^BITWIDTH cycles. Presents each finished output tile through a valid/ready handshake and signals job completion.

Parameters:
BITWIDTH, 8, operand precision; unary stream period RUNLEN = 2^BITWIDTH cycles.
DIMW, 8, width of tile-count inputs and index outputs.
DRAIN_CYC, 2, cycles between the last enabled cycle and the output capture (array pipeline depth); legal range 1..15.

Ports:
iClk  input  1  clock
iRst  input  1  synchronous active-high reset
iStart  input  1  start job; sampled only in IDLE
iNumM  input  DIMW  row-tile count; latched on accepted start
iNumN  input  DIMW  column-tile count; latched on accepted start
iNumK  input  DIMW  reduction-chunk count; latched on accepted start
oBusy  output  1  high from the accepted start until DONE inclusive
oDone  output  1  one-cycle pulse at job end
oFetchReq  output  1  operand chunk request
oFetchM  output  DIMW  row-tile index of the request
oFetchN  output  DIMW  column-tile index of the request
oFetchK  output  DIMW  chunk index of the request
iFetchAck  input  1  operand chunk delivered
oArrClr  output  1  clear array accumulators
oArrLoad  output  1  load operand registers
oArrEn  output  1  array stream enable
oOutValid  output  1  output tile ready for capture
iOutReady  input  1  consumer accepts the tile
oOutM  output  DIMW  row-tile index of the output
oOutN  output  DIMW  column-tile index of the output

Behaviour:
- One clock (iClk). Reset is synchronous and active-high (iRst).
- On reset, the FSM goes to IDLE, all counters go to 0, and every output is 0. Reset mid-job abandons the job with no oDone.
- All outputs are registered except oArrLoad, which equals (state==FETCH & iFetchAck).
- States: IDLE, CLR, FETCH, RUN, DRAIN, OUT, DONE.
- IDLE: on iStart, latch the three counts.
  - If any count is 0, go to DONE (no array activity).
  - Otherwise go to CLR with m=n=k=0.
- CLR: one cycle with oArrClr=1, then go to FETCH.
- FETCH: oFetchReq=1 and oFetch{M,N,K}=current m,n,k.
  - Hold the request and indices stable until iFetchAck.
  - Ack in the first FETCH cycle is accepted (zero-wait).
  - On ack, pulse oArrLoad and go to RUN.
  - iFetchAck outside FETCH is ignored.
- RUN: oArrEn=1 for exactly RUNLEN consecutive cycles, counted by a BITWIDTH-bit counter that wraps to 0.
  - If k < iNumK-1: increment k and go to FETCH.
  - Else: k=0 and go to DRAIN.
- DRAIN: DRAIN_CYC cycles with oArrEn=0, then go to OUT.
- OUT: oOutValid=1 with oOutM=m and oOutN=n, held stable until iOutReady (ready in the first cycle is allowed).
  - On handshake, advance to the next tile, n fastest: n+1, else n=0 and m+1.
  - If the completed tile was the last (m=iNumM-1, n=iNumN-1), go to DONE; else go to CLR.
- DONE: oDone=1 for one cycle, then go to IDLE. iStart in DONE is ignored.
- iStart while busy is ignored. Latched counts are unaffected by input changes mid-job.
- Minimum tile latency: 1 + iNumK*(1+RUNLEN) + DRAIN_CYC + 1 cycles.

Decomposition:
- Shared package outerprodrc_ctrl_pkg holds:
  - the state enum (7 states, 3-bit encoding);
  - the RUNLEN constant function of BITWIDTH;
  - the DIMW default.
- One natural sub-module, outerprodrc_ctrl_idx: a nested m/n/k index counter with inc_k, inc_tile and clear inputs, plus last_k and last_tile flags.
- The FSM and stream counter stay in the top module.

Test Plan:
- BITWIDTH=3, DRAIN_CYC=2, M=N=K=1, ack and ready tied 1, start at cycle 0 -> CLR@1, FETCH+Load@2, En@3..10, DRAIN@11..12, OutValid@13 (M=N=0), Done@14, Busy@1..14.
- M=2, N=3, K=1, immediate ack/ready -> six OUT handshakes in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); exactly one oDone after the sixth; Clr pulses exactly six times.
- K=3 with iFetchAck delayed 4 cycles each -> oFetchReq held for 5 cycles per chunk with stable indices K=0,1,2; exactly 3 Load pulses and 3*RUNLEN En cycles per tile.
- iOutReady withheld 10 cycles -> oOutValid, oOutM and oOutN stable for 11 cycles; no Clr/En until the handshake.
- iNumK=0 with start -> Busy for one cycle, oDone the following... (DONE state) with no FetchReq/En/Clr; iStart pulses during a running job are ignored with no count relatch.
- iRst asserted mid-RUN -> next cycle all outputs 0 and state IDLE; a subsequent start runs a full job correctly from index 0.
